uart_receive: RTL
=================

Name: uart_receive

Overview:
- Receive end of the one-wire UART link driven by uart_transmit.
- Frame format: idle high, start bit 0, d_width data bits LSB first, stop bit 1.
- Deserializes the incoming frame into a one-entry holding register, then presents it to the consumer with a valid/ack handshake.
- Flags framing errors and overruns. Lives in the same clock domain as the transmitter, so there is no input synchronizer.

Parameters:
- d_width, 4: data bits per frame. Must match the transmitter.
- clks_per_bit, 1: clock cycles per bit. 1 matches uart_transmit's one-bit-per-clock line rate. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line, idle high.
- rx_ack  input  1  consumer has taken rx_data; clears rx_valid.
- rx_data  output  d_width  last good frame, LSB = first data bit received.
- rx_valid  output  1  rx_data holds an unconsumed frame.
- rx_busy  output  1  frame reception in progress.
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  output  1  one-cycle pulse: good frame overwrote an unacked one.

Behaviour:
- Reset values:
  - rx_data = 0, rx_valid = 0, rx_busy = 0, rx_frame_err = 0, rx_overrun = 0.
  - State = IDLE, armed = 0, all counters = 0.
- Arming: after reset or after BREAK, rx must be sampled 1 for at least one cycle (armed = 1) before a start can be accepted. A receiver reset mid-frame therefore never resyncs on a data bit.
- Bit indexing: t0 is the first cycle rx = 0 while IDLE and armed. Bit k is sampled at t0 + k*clks_per_bit + (clks_per_bit-1)/2 (integer division). k = 0 is start, k = 1..d_width are data, k = d_width+1 is stop.
- States:
  - IDLE: rx_busy = 0. On rx = 0 and armed, go to START and load the sample counter.
  - START: at the bit-0 sample point, if rx = 1 the start was a glitch: return to IDLE with no flags. Otherwise go to DATA. With clks_per_bit = 1 the start sample is the t0 sample itself, so the next cycle is already data bit 1.
  - DATA: at each sample point, shift rx into the MSB of the shift register (right shift). After d_width samples, go to STOP.
  - STOP: at the sample point:
    - rx = 1: write the shift register to rx_data and set rx_valid the following cycle. Go to IDLE, armed = 1.
    - rx = 0: pulse rx_frame_err the following cycle, discard data, leave rx_data and rx_valid unchanged, go to BREAK.
  - BREAK: wait for rx = 1, then go to IDLE, armed = 1.
- rx_busy: high from the cycle after t0 through the stop-sample cycle inclusive.
- Back-to-back frames: a start may be detected in the cycle immediately after a good stop sample. No extra idle time is required beyond the stop bit.
- Latency: with clks_per_bit = 1, rx_valid rises at t0 + d_width + 2.
- Handshake:
  - rx_valid stays high until a cycle with rx_ack = 1, which clears it on the next edge.
  - rx_ack while rx_valid = 0 is ignored.
- Simultaneous events:
  - A good stop while rx_valid = 1 and rx_ack = 0: rx_data is overwritten, rx_valid stays 1, rx_overrun pulses.
  - A good stop in the same cycle as rx_ack: rx_data is updated, rx_valid stays 1, no overrun.
  - A framing error coincident with rx_ack: rx_valid clears normally.
- Widths:
  - Sample counter is clog2(clks_per_bit)+1 bits; it reloads at every sample point and never wraps mid-bit.
  - Bit counter is clog2(d_width+2) bits.
- rst takes priority over every other condition in every state.

Test Plan:
1. Defaults, clks_per_bit=1, driven by uart_transmit: tx_ena pulse with tx_data=4'hA.
   - Line shows 0,0,1,0,1,1.
   - rx_valid rises 6 cycles after start detection with rx_data=4'hA. rx_busy is high for cycles t0+1..t0+5.
2. Two back-to-back frames 4'h3 then 4'hC, no ack:
   - rx_data=4'hC, rx_overrun pulses once, rx_valid stays 1.
   - Repeat with rx_ack asserted in the second frame's stop-sample cycle: no overrun.
3. Frame 4'h5 with stop bit forced 0, then line held 0 for 3 cycles, then 1:
   - rx_frame_err pulses once, rx_valid stays 0, rx_busy=0 through BREAK.
   - Next frame 4'h6 is received correctly.
4. clks_per_bit=4, frame 4'h9 driven at 4 clocks/bit:
   - Samples land at offsets 1, 5, 9, …; rx_data=4'h9.
   - A 1-cycle low glitch on an idle line is rejected: no busy after the start check, no flags.
5. rst asserted at data bit 2 while line still carries the frame, then released:
   - All outputs return to 0.
   - The remaining 0 bits do not start a frame until rx is seen 1.
   - The following frame 4'hF is received correctly.
6. Handshake corner: rx_ack held high with rx_valid=0, then a frame 4'h1 arrives:
   - rx_valid pulses for exactly one cycle, because the ack is still asserted.
   - Releasing ack before the next frame holds rx_valid high.

Source files
------------

// File: rtl/uart_receive.sv
// UART receiver: start/data/stop deserializer into a one-entry holding register
// with a valid/ack handshake, framing-error and overrun pulses.
module uart_receive #(
    parameter int d_width      = 4,
    parameter int clks_per_bit = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ack,
    output logic [d_width-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_frame_err,
    output logic               rx_overrun
);
    localparam int half  = (clks_per_bit - 1) / 2;
    localparam int cnt_w = $clog2(clks_per_bit) + 1;
    localparam int bit_w = $clog2(d_width + 2);

    localparam logic [cnt_w-1:0] cnt_bit  = cnt_w'(clks_per_bit - 1);
    localparam logic [cnt_w-1:0] cnt_half = cnt_w'((half > 0) ? half - 1 : 0);
    localparam logic [bit_w-1:0] bit_last = bit_w'(d_width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t             state;
    logic               armed;
    logic [cnt_w-1:0]   cnt;
    logic [bit_w-1:0]   bit_cnt;
    logic [d_width-1:0] shift;
    logic               sample;

    assign sample = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            armed        <= 1'b0;
            cnt          <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_busy      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            if (rx_ack)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        rx_busy <= 1'b1;
                        bit_cnt <= '0;
                        // With a zero half-bit offset the detection cycle is the start sample.
                        if (half == 0) begin
                            state <= DATA;
                            cnt   <= cnt_bit;
                        end else begin
                            state <= START;
                            cnt   <= cnt_half;
                        end
                    end
                end
                START: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state <= DATA;
                        cnt   <= cnt_bit;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {rx, shift[d_width-1:1]};
                        cnt   <= cnt_bit;
                        if (bit_cnt == bit_last)
                            state <= STOP;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rx_busy <= 1'b0;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        if (rx) begin
                            // A coincident ack frees the slot, so that case is not an overrun.
                            rx_data    <= shift;
                            rx_valid   <= 1'b1;
                            rx_overrun <= rx_valid & ~rx_ack;
                            armed      <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            armed        <= 1'b0;
                            state        <= BRK;
                        end
                    end
                end
                BRK: begin
                    if (rx) begin
                        armed <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
